alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multi-cycle issue/capture controller in front of the combinational ALU of mini_cpu.
- Accepts one operation at a time over a valid/ready request interface and drives registered, stable A/B/op into the ALU.
- Waits an op-class-dependent number of settle cycles (mul and div are deep combinational paths), then captures Zhigh/Zlow into result registers and presents them over a valid/ready result interface.

Parameters:
SIMPLE_WAIT, 1, settle cycles for add/sub/logic/shift/rotate/neg/not (>=1)
MUL_WAIT, 4, settle cycles for mul (>=1)
DIV_WAIT, 8, settle cycles for div (>=1)
CNT_W, 4, width of settle counter; must hold max(*_WAIT)-1

Ports:
clock  in  1  system clock, rising edge
clear  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted this edge if req_valid also high
req_op  in  5  ALU opcode
req_a  in  32  operand A
req_b  in  32  operand B
alu_a  out  32  registered A to ALU
alu_b  out  32  registered B to ALU
alu_op  out  5  registered op to ALU
alu_zlo  in  32  ALU Zlowout
alu_zhi  in  32  ALU Zhighout
res_valid  out  1  result registers hold a result
res_ready  in  1  consumer takes result this edge if res_valid also high
res_lo  out  32  captured low word
res_hi  out  32  captured high word
res_err  out  1  result is an error (illegal op / div0)
busy  out  1  high in WAIT or DONE

Behaviour:
- Reset (clear low, async): state IDLE; alu_a, alu_b, res_lo, res_hi = 0; alu_op = 0; res_valid = res_err = 0; counter = 0. Reset mid-operation abandons the operation; no result is produced.
- Legal opcodes: 00011, 01100 (add); 00100 (sub); 01010, 01101 (and); 01011, 01110 (or); 00101, 00110 (shr, shra); 00111 (shl); 01000, 01001 (ror, rol); 10001 (neg); 10010 (not); 01111 (mul); 10000 (div). All other codes are illegal.
- Wait class W: mul uses MUL_WAIT, div uses DIV_WAIT, other legal ops use SIMPLE_WAIT, illegal ops use 1.
- req_ready = (state==IDLE) | (state==DONE & res_ready). This is combinational.
- States:
  - IDLE: on accept, load alu_a/alu_b/alu_op from req_*; counter = W-1; go to WAIT.
  - WAIT: alu_* are held constant. If counter != 0, decrement. If counter == 0, capture and go to DONE: res_lo/res_hi = alu_zlo/alu_zhi and res_err = 0 for a legal op; res_lo/res_hi = 0 and res_err = 1 for an illegal op; res_valid = 1.
  - DONE: res_* are held constant while res_valid=1 & res_ready=0.
    - res_ready=1 & req_valid=0: res_valid=0, go to IDLE.
    - res_ready=1 & req_valid=1: retire and accept on the same edge (load new operands, go to WAIT, res_valid=0). This gives back-to-back issue.
- Latency: accept at edge k gives res_valid high after edge k+W. Throughput is one op per W+1 cycles with res_ready tied high.
- res_lo/res_hi/res_err keep their last values after retirement; they are only valid while res_valid=1.
- req_* are ignored whenever req_ready=0.
- alu_* retain their last values in IDLE and DONE.

Optional Feature:
- Macro: ALU_SEQ_DIV0_CHECK_EN.
- Defined: a div with req_b == 0 is treated as illegal. W=1, res_lo = res_hi = 0, res_err = 1.
- Undefined: div by zero runs the normal DIV_WAIT and captures whatever the ALU outputs, with res_err = 0.

Test Plan:
- Add: op 00011, A=5, B=7, res_ready=1. Expect res_valid one edge after accept, res_lo=12, res_hi=0, res_err=0, busy low next cycle.
- Mul: op 01111, A=3, B=0xFFFFFFFE. Expect res_valid after edge k+4, res_hi=0xFFFFFFFF, res_lo=0xFFFFFFFA, and alu_a/alu_b stable through WAIT.
- Div: op 10000, A=17, B=5. Expect res_valid after edge k+8, res_lo=3, res_hi=2. With ALU_SEQ_DIV0_CHECK_EN and B=0, expect res_valid after k+1, res_err=1, res_lo=res_hi=0.
- Backpressure and back-to-back: hold res_ready=0 for 5 cycles after an add result. Expect res_* constant and req_ready=0. Then raise res_ready with a sub 10-3 pending: expect same-edge accept, then res_lo=7.
- Illegal op: op 11111. Expect res_valid after k+1, res_err=1, res_lo=res_hi=0.
- Reset: drop clear mid-WAIT of a div. Expect all outputs 0 immediately, and after release the next add completes normally.

Source files
------------

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//
// Issue/capture controller placed in front of the combinational mini_cpu ALU.
// One operation is accepted at a time over a valid/ready request interface.
// Operands and opcode are registered and held stable on alu_a/alu_b/alu_op.
// The controller then waits an op-class-dependent number of settle cycles,
// because mul and div are deep combinational paths. It then captures
// Zhigh/Zlow into result registers and presents them over a valid/ready
// result interface.
//
// Optional feature (compile-time macro ALU_SEQ_DIV0_CHECK_EN):
//   defined   - a div whose req_b is zero is treated as an illegal op.
//               It completes after one cycle with res_err=1 and a zero result.
//   undefined - a div by zero runs the normal DIV_WAIT and captures whatever
//               the ALU drives, with res_err=0.
//
// Ports:
//   clock      in   1   system clock, rising edge
//   clear      in   1   asynchronous active-low reset
//   req_valid  in   1   request present
//   req_ready  out  1   request accepted on this edge if req_valid is high
//   req_op     in   5   ALU opcode
//   req_a      in  32   operand A
//   req_b      in  32   operand B
//   alu_a      out 32   registered A driven to the ALU
//   alu_b      out 32   registered B driven to the ALU
//   alu_op     out  5   registered opcode driven to the ALU
//   alu_zlo    in  32   ALU Zlow output
//   alu_zhi    in  32   ALU Zhigh output
//   res_valid  out  1   result registers hold a result
//   res_ready  in   1   consumer takes the result on this edge if res_valid
//   res_lo     out 32   captured low word
//   res_hi     out 32   captured high word
//   res_err    out  1   result is an error (illegal op / div by zero)
//   busy       out  1   high in WAIT or DONE
// ---------------------------------------------------------------------------
module alu_sequencer #(
    parameter int SIMPLE_WAIT = 1,
    parameter int MUL_WAIT    = 4,
    parameter int DIV_WAIT    = 8,
    parameter int CNT_W       = 4
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_op,
    input  logic [31:0] alu_zlo,
    input  logic [31:0] alu_zhi,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_lo,
    output logic [31:0] res_hi,
    output logic        res_err,
    output logic        busy
);

    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_alu_a;
    logic [31:0]        r_alu_b;
    logic [4:0]         r_alu_op;
    logic               r_illegal;
    logic [31:0]        r_res_lo;
    logic [31:0]        r_res_hi;
    logic               r_res_err;
    logic               r_res_valid;

    logic               w_req_ready;
    logic               w_accept;
    logic               w_capture;
    logic               w_retire;
    logic               w_req_illegal;
    logic [CNT_W-1:0]   w_cnt_init;

    // Opcode decode: every code outside this list is illegal.
    function automatic logic op_is_legal(input logic [4:0] op);
        case (op)
            5'b00011, 5'b01100,                 // add
            5'b00100,                           // sub
            5'b01010, 5'b01101,                 // and
            5'b01011, 5'b01110,                 // or
            5'b00101, 5'b00110,                 // shr, shra
            5'b00111,                           // shl
            5'b01000, 5'b01001,                 // ror, rol
            5'b10001,                           // neg
            5'b10010,                           // not
            5'b01111,                           // mul
            5'b10000:                           // div
                op_is_legal = 1'b1;
            default:
                op_is_legal = 1'b0;
        endcase
    endfunction

    // Counter start value is (settle cycles - 1).
    // The capture happens on the edge where the counter is already zero.
    function automatic logic [CNT_W-1:0] wait_init(input logic [4:0] op,
                                                   input logic       illegal);
        if (illegal)
            wait_init = '0;
        else if (op == OP_MUL)
            wait_init = CNT_W'(MUL_WAIT - 1);
        else if (op == OP_DIV)
            wait_init = CNT_W'(DIV_WAIT - 1);
        else
            wait_init = CNT_W'(SIMPLE_WAIT - 1);
    endfunction

`ifdef ALU_SEQ_DIV0_CHECK_EN
    assign w_req_illegal = !op_is_legal(req_op) ||
                           ((req_op == OP_DIV) && (req_b == 32'd0));
`else
    assign w_req_illegal = !op_is_legal(req_op);
`endif

    assign w_cnt_init  = wait_init(req_op, w_req_illegal);

    // Ready in IDLE, or in DONE when the current result leaves on this edge.
    // The second case gives back-to-back issue.
    assign w_req_ready = (r_state == S_IDLE) ||
                         ((r_state == S_DONE) && res_ready);
    assign w_accept    = req_valid && w_req_ready;
    assign w_capture   = (r_state == S_WAIT) && (r_cnt == '0);
    assign w_retire    = (r_state == S_DONE) && res_ready;

    // State register
    always_ff @(posedge clock or negedge clear) begin
        if (!clear)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid)
                    w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == '0)
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (res_ready)
                    w_state_nxt = req_valid ? S_WAIT : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Issue side: operand registers and settle counter
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_op  <= '0;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_alu_a   <= req_a;
            r_alu_b   <= req_b;
            r_alu_op  <= req_op;
            r_cnt     <= w_cnt_init;
            r_illegal <= w_req_illegal;
        end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Capture side: result registers keep their values after retirement.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_res_lo    <= '0;
            r_res_hi    <= '0;
            r_res_err   <= 1'b0;
            r_res_valid <= 1'b0;
        end else if (w_capture) begin
            r_res_valid <= 1'b1;
            r_res_err   <= r_illegal;
            r_res_lo    <= r_illegal ? 32'd0 : alu_zlo;
            r_res_hi    <= r_illegal ? 32'd0 : alu_zhi;
        end else if (w_retire) begin
            r_res_valid <= 1'b0;
        end
    end

    assign req_ready = w_req_ready;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign res_valid = r_res_valid;
    assign res_lo    = r_res_lo;
    assign res_hi    = r_res_hi;
    assign res_err   = r_res_err;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

    logic        clock;
    logic        clear;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_op;
    logic [31:0] alu_zlo;
    logic [31:0] alu_zhi;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_lo;
    logic [31:0] res_hi;
    logic        res_err;
    logic        busy;

    int n_checks;
    int n_fail;

    alu_sequencer dut (
        .clock     (clock),
        .clear     (clear),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_zlo   (alu_zlo),
        .alu_zhi   (alu_zhi),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_lo    (res_lo),
        .res_hi    (res_hi),
        .res_err   (res_err),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stand-in for the mini_cpu ALU: only the ops exercised here.
    // Anything else drives a recognisable junk pattern.
    always_comb begin
        logic signed [63:0] prod;
        prod    = $signed(alu_a) * $signed(alu_b);
        alu_zlo = 32'hDEADBEEF;
        alu_zhi = 32'hDEADBEEF;
        case (alu_op)
            5'b00011: begin alu_zlo = alu_a + alu_b; alu_zhi = 32'd0; end
            5'b00100: begin alu_zlo = alu_a - alu_b; alu_zhi = 32'd0; end
            5'b01111: begin alu_zlo = prod[31:0]; alu_zhi = prod[63:32]; end
            5'b10000: begin
                if (alu_b != 32'd0) begin
                    alu_zlo = alu_a / alu_b;
                    alu_zhi = alu_a % alu_b;
                end
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one active edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present a request and let the accepting edge happen.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        #1;
        chk("req_ready_before_issue", {63'd0, req_ready}, 64'd1);
        step();
        req_valid = 1'b0;
    endtask

    // After an accept edge, expect n-1 idle cycles, then res_valid on edge k+n.
    task automatic wait_result(input string tag, input int n);
        for (int i = 1; i < n; i++) begin
            chk({tag, "_not_yet"}, {63'd0, res_valid}, 64'd0);
            step();
        end
        chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
        step();
        chk({tag, "_valid"}, {63'd0, res_valid}, 64'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        clear     = 1'b0;
        req_valid = 1'b0;
        req_op    = 5'd0;
        req_a     = 32'd0;
        req_b     = 32'd0;
        res_ready = 1'b1;

        // Reset state
        repeat (2) step();
        chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
        chk("rst_busy",      {63'd0, busy},      64'd0);
        chk("rst_alu_a",     {32'd0, alu_a},     64'd0);
        chk("rst_res_lo",    {32'd0, res_lo},    64'd0);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        clear = 1'b1;
        step();

        // Add 5+7, one settle cycle
        issue(5'b00011, 32'd5, 32'd7);
        chk("add_alu_a", {32'd0, alu_a}, 64'd5);
        wait_result("add", 1);
        chk("add_lo",  {32'd0, res_lo},    64'd12);
        chk("add_hi",  {32'd0, res_hi},    64'd0);
        chk("add_err", {63'd0, res_err},   64'd0);
        step();
        chk("add_retire_valid", {63'd0, res_valid}, 64'd0);
        chk("add_retire_busy",  {63'd0, busy},      64'd0);

        // Illegal opcode: one cycle, zero result, error flag
        issue(5'b11111, 32'd9, 32'd9);
        wait_result("ill", 1);
        chk("ill_err", {63'd0, res_err}, 64'd1);
        chk("ill_lo",  {32'd0, res_lo},  64'd0);
        chk("ill_hi",  {32'd0, res_hi},  64'd0);
        step();

        // Mul 3 * -2 = -6, four settle cycles, operands held
        issue(5'b01111, 32'd3, 32'hFFFFFFFE);
        for (int i = 1; i < 4; i++) begin
            chk("mul_not_yet", {63'd0, res_valid}, 64'd0);
            chk("mul_hold_a",  {32'd0, alu_a},     64'd3);
            chk("mul_hold_b",  {32'd0, alu_b},     64'h00000000FFFFFFFE);
            step();
        end
        step();
        chk("mul_valid", {63'd0, res_valid}, 64'd1);
        chk("mul_lo",    {32'd0, res_lo},    64'h00000000FFFFFFFA);
        chk("mul_hi",    {32'd0, res_hi},    64'h00000000FFFFFFFF);
        chk("mul_err",   {63'd0, res_err},   64'd0);
        step();

        // Div 17/5: quotient 3 in lo, remainder 2 in hi, eight settle cycles
        issue(5'b10000, 32'd17, 32'd5);
        wait_result("div", 8);
        chk("div_lo",  {32'd0, res_lo},  64'd3);
        chk("div_hi",  {32'd0, res_hi},  64'd2);
        chk("div_err", {63'd0, res_err}, 64'd0);
        step();

        // Div by zero
        issue(5'b10000, 32'd17, 32'd0);
`ifdef ALU_SEQ_DIV0_CHECK_EN
        wait_result("div0", 1);
        chk("div0_err", {63'd0, res_err}, 64'd1);
        chk("div0_lo",  {32'd0, res_lo},  64'd0);
        chk("div0_hi",  {32'd0, res_hi},  64'd0);
`else
        wait_result("div0", 8);
        chk("div0_err", {63'd0, res_err}, 64'd0);
        chk("div0_lo",  {32'd0, res_lo},  64'h00000000DEADBEEF);
`endif
        step();

        // Backpressure: hold the add 1+2 result for 5 cycles with a sub pending
        res_ready = 1'b0;
        issue(5'b00011, 32'd1, 32'd2);
        wait_result("bp", 1);
        req_valid = 1'b1;
        req_op    = 5'b00100;
        req_a     = 32'd10;
        req_b     = 32'd3;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
            step();
            chk("bp_valid",  {63'd0, res_valid}, 64'd1);
            chk("bp_lo",     {32'd0, res_lo},    64'd3);
            chk("bp_alu_op", {59'd0, alu_op},    64'h03);
        end
        res_ready = 1'b1;
        #1;
        chk("b2b_req_ready", {63'd0, req_ready}, 64'd1);
        step();
        req_valid = 1'b0;
        chk("b2b_valid_drop", {63'd0, res_valid}, 64'd0);
        chk("b2b_alu_op",     {59'd0, alu_op},    64'h04);
        chk("b2b_busy",       {63'd0, busy},      64'd1);
        step();
        chk("sub_valid", {63'd0, res_valid}, 64'd1);
        chk("sub_lo",    {32'd0, res_lo},    64'd7);
        step();

        // Reset in the middle of a div
        issue(5'b10000, 32'd100, 32'd7);
        repeat (3) step();
        clear = 1'b0;
        #1;
        chk("mid_rst_valid",  {63'd0, res_valid}, 64'd0);
        chk("mid_rst_busy",   {63'd0, busy},      64'd0);
        chk("mid_rst_alu_a",  {32'd0, alu_a},     64'd0);
        chk("mid_rst_alu_b",  {32'd0, alu_b},     64'd0);
        chk("mid_rst_alu_op", {59'd0, alu_op},    64'd0);
        chk("mid_rst_lo",     {32'd0, res_lo},    64'd0);
        chk("mid_rst_err",    {63'd0, res_err},   64'd0);
        step();
        clear = 1'b1;
        step();
        chk("post_rst_valid", {63'd0, res_valid}, 64'd0);
        issue(5'b00011, 32'd5, 32'd7);
        wait_result("post_rst_add", 1);
        chk("post_rst_lo", {32'd0, res_lo}, 64'd12);
        step();
        chk("post_rst_idle", {63'd0, busy}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
